// File: rtl/operand_fanout_queue.sv
// operand_fanout_queue
// Buffers VRF read data and fans each beat out to a set of consumer ports.
// A command (beat count + consumer mask) selects which consumers receive the
// next cmd_len beats. A beat leaves the data FIFO only after every masked
// consumer has accepted it. Consumers may accept in any order and each one
// sees the beat exactly once. Read credits keep the data FIFO from overflowing.
//
// Optional feature: define ARA_OPQ_BYPASS_EN to forward incoming data straight
// to the consumers when the data FIFO is empty, which gives zero-cycle latency.
//
// FSM states:
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | command FIFO empty, nothing offered
//   ST_STREAM | head command active, beats offered to consumers
module operand_fanout_queue #(
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned DataBufDepth = 4,
    parameter int unsigned CmdBufDepth  = 4,
    parameter int unsigned NrConsumers  = 3,
    parameter int unsigned LenWidth     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [LenWidth-1:0]    cmd_len_i,
    input  logic [NrConsumers-1:0] cmd_mask_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   operand_issued_i,
    output logic                   operand_queue_ready_o,
    input  logic [DataWidth-1:0]   operand_i,
    input  logic                   operand_valid_i,
    output logic [DataWidth-1:0]   operand_o,
    output logic [NrConsumers-1:0] operand_valid_o,
    input  logic [NrConsumers-1:0] operand_ready_i,
    output logic                   busy_o,
    output logic                   error_o
);

    localparam int unsigned DPtrW = (DataBufDepth > 1) ? $clog2(DataBufDepth) : 1;
    localparam int unsigned DCntW = $clog2(DataBufDepth + 1);
    localparam int unsigned CPtrW = (CmdBufDepth > 1) ? $clog2(CmdBufDepth) : 1;
    localparam int unsigned CCntW = $clog2(CmdBufDepth + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [DataWidth-1:0]   data_mem [DataBufDepth];
    logic [DPtrW-1:0]       data_wr_ptr, data_rd_ptr;
    logic [DCntW-1:0]       data_cnt;

    logic [LenWidth-1:0]    cmd_len_mem  [CmdBufDepth];
    logic [NrConsumers-1:0] cmd_mask_mem [CmdBufDepth];
    logic [CPtrW-1:0]       cmd_wr_ptr, cmd_rd_ptr;
    logic [CCntW-1:0]       cmd_cnt;
    logic [CCntW-1:0]       cmd_cnt_next;

    logic [DCntW-1:0]       inflight;
    logic [DCntW:0]         occupancy;
    logic [LenWidth-1:0]    beat_cnt;
    logic [NrConsumers-1:0] taken;
    logic [0:0]             state;

    logic                   data_empty, data_full, cmd_empty, cmd_full;
    logic                   cmd_push, cmd_pop, data_push, data_pop;
    logic                   credit_ok, data_accept;
    logic                   streaming, active, bypass_sel, beat_avail, offer;
    logic                   retire, last_beat;
    logic [LenWidth-1:0]    head_len;
    logic [NrConsumers-1:0] head_mask, hs;

    // Queue status, head command, credit and handshake decode
    always_comb begin
        data_empty   = (data_cnt == '0);
        data_full    = (data_cnt == DCntW'(DataBufDepth));
        cmd_empty    = (cmd_cnt == '0);
        cmd_full     = (cmd_cnt == CCntW'(CmdBufDepth));
        cmd_ready_o  = !cmd_full;
        cmd_push     = cmd_valid_i && !cmd_full;
        head_len     = cmd_len_mem[cmd_rd_ptr];
        head_mask    = cmd_mask_mem[cmd_rd_ptr];

        // Data is only legal while a read is outstanding (or issued this cycle).
        credit_ok    = (inflight != '0) || operand_issued_i;
        data_accept  = operand_valid_i && credit_ok;

        streaming    = (state == ST_STREAM) && !cmd_empty;
        active       = streaming && (head_len != '0);

`ifdef ARA_OPQ_BYPASS_EN
        bypass_sel   = active && data_empty;
        beat_avail   = bypass_sel ? data_accept : !data_empty;
        operand_o    = bypass_sel ? operand_i
                                  : (data_empty ? '0 : data_mem[data_rd_ptr]);
`else
        bypass_sel   = 1'b0;
        beat_avail   = !data_empty;
        operand_o    = data_empty ? '0 : data_mem[data_rd_ptr];
`endif

        offer           = active && beat_avail;
        operand_valid_o = offer ? (head_mask & ~taken) : '0;
        hs              = operand_valid_o & operand_ready_i;

        // An unmasked consumer counts as done, so a zero mask discards each beat.
        retire       = offer && (&(~head_mask | taken | hs));
        last_beat    = (beat_cnt == (head_len - LenWidth'(1)));
        cmd_pop      = streaming && ((head_len == '0) || (retire && last_beat));
        cmd_cnt_next = cmd_cnt + CCntW'(cmd_push) - CCntW'(cmd_pop);

        data_pop     = retire && !bypass_sel;
        // A bypassed word that retires at once never enters the FIFO.
        data_push    = data_accept && (!data_full || data_pop) && !(bypass_sel && retire);

        occupancy             = {1'b0, data_cnt} + {1'b0, inflight};
        operand_queue_ready_o = (occupancy < (DCntW+1)'(DataBufDepth));
        busy_o                = !cmd_empty || (data_cnt != '0) || (inflight != '0);
    end

    // Data FIFO storage (no reset needed; validity is tracked by data_cnt)
    always_ff @(posedge clk_i) begin
        if (data_push) begin
            data_mem[data_wr_ptr] <= operand_i;
        end
    end

    // Command FIFO storage
    always_ff @(posedge clk_i) begin
        if (cmd_push) begin
            cmd_len_mem[cmd_wr_ptr]  <= cmd_len_i;
            cmd_mask_mem[cmd_wr_ptr] <= cmd_mask_i;
        end
    end

    // Data FIFO pointers and fill level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_wr_ptr <= '0;
            data_rd_ptr <= '0;
            data_cnt    <= '0;
        end else begin
            if (data_push) begin
                data_wr_ptr <= (data_wr_ptr == DPtrW'(DataBufDepth - 1)) ? '0 : data_wr_ptr + 1'b1;
            end
            if (data_pop) begin
                data_rd_ptr <= (data_rd_ptr == DPtrW'(DataBufDepth - 1)) ? '0 : data_rd_ptr + 1'b1;
            end
            data_cnt <= data_cnt + DCntW'(data_push) - DCntW'(data_pop);
        end
    end

    // Command FIFO pointers and fill level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_cnt    <= '0;
        end else begin
            if (cmd_push) begin
                cmd_wr_ptr <= (cmd_wr_ptr == CPtrW'(CmdBufDepth - 1)) ? '0 : cmd_wr_ptr + 1'b1;
            end
            if (cmd_pop) begin
                cmd_rd_ptr <= (cmd_rd_ptr == CPtrW'(CmdBufDepth - 1)) ? '0 : cmd_rd_ptr + 1'b1;
            end
            cmd_cnt <= cmd_cnt_next;
        end
    end

    // Outstanding read credits and sticky error for uncredited data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight <= '0;
            error_o  <= 1'b0;
        end else begin
            if (operand_issued_i && !data_accept) begin
                inflight <= inflight + 1'b1;
            end else if (!operand_issued_i && data_accept) begin
                inflight <= inflight - 1'b1;
            end
            if (operand_valid_i && !credit_ok) begin
                error_o <= 1'b1;
            end
        end
    end

    // Beat counter and per-consumer taken flags for the head beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt <= '0;
            taken    <= '0;
        end else begin
            if (cmd_pop) begin
                beat_cnt <= '0;
            end else if (retire) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (retire) begin
                taken <= '0;
            end else begin
                taken <= taken | hs;
            end
        end
    end

    // IDLE/STREAM sequencing
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (!cmd_empty) state <= ST_STREAM;
                ST_STREAM: if (cmd_pop && (cmd_cnt_next == '0)) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fanout_queue.sv
// Self-checking bench for operand_fanout_queue (default parameters).
module tb_operand_fanout_queue;

    localparam int DW = 64;
    localparam int NC = 3;
    localparam int LW = 16;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [LW-1:0]   cmd_len_i;
    logic [NC-1:0]   cmd_mask_i;
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic            operand_issued_i;
    logic            operand_queue_ready_o;
    logic [DW-1:0]   operand_i;
    logic            operand_valid_i;
    logic [DW-1:0]   operand_o;
    logic [NC-1:0]   operand_valid_o;
    logic [NC-1:0]   operand_ready_i;
    logic            busy_o;
    logic            error_o;

    operand_fanout_queue #(
        .DataWidth(DW), .DataBufDepth(4), .CmdBufDepth(4),
        .NrConsumers(NC), .LenWidth(LW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_len_i(cmd_len_i), .cmd_mask_i(cmd_mask_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .operand_issued_i(operand_issued_i),
        .operand_queue_ready_o(operand_queue_ready_o),
        .operand_i(operand_i), .operand_valid_i(operand_valid_i),
        .operand_o(operand_o), .operand_valid_o(operand_valid_o),
        .operand_ready_i(operand_ready_i),
        .busy_o(busy_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int            len;
        logic [NC-1:0] mask;
        bit            rnd_ready;
        int            exp_hs;
    } vec_t;

    vec_t          vecs[8];
    logic [DW-1:0] exp_q[NC][$];
    logic [NC-1:0] cur_mask;
    int            cmp_cnt = 0;
    int            err_cnt = 0;
    int            hs_total = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    // Scoreboard side: every handshake must deliver the oldest expected word.
    task automatic monitor();
        for (int i = 0; i < NC; i++) begin
            if (operand_valid_o[i] && operand_ready_i[i]) begin
                hs_total++;
                if (exp_q[i].size() == 0) begin
                    cmp_cnt++;
                    err_cnt++;
                    $display("FAIL hs_extra_c%0d: got handshake with data %0h, required none", i, operand_o);
                end else begin
                    check($sformatf("hs_data_c%0d", i), operand_o, exp_q[i].pop_front());
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        monitor();
        @(negedge clk_i);
    endtask

    task automatic send_data();
        operand_valid_i = 1'b1;
        operand_i       = {$urandom, $urandom};
        for (int i = 0; i < NC; i++) begin
            if (cur_mask[i]) exp_q[i].push_back(operand_i);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid_i      = 1'b0;
        cmd_len_i        = '0;
        cmd_mask_i       = '0;
        operand_issued_i = 1'b0;
        operand_valid_i  = 1'b0;
        operand_i        = '0;
        operand_ready_i  = '0;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NC; i++) exp_q[i].delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"},   64'(cmd_ready_o), 64'(1));
        check({tag, "_queue_ready"}, 64'(operand_queue_ready_o), 64'(1));
        check({tag, "_valid_o"},     64'(operand_valid_o), 64'(0));
        check({tag, "_operand_o"},   operand_o, 64'(0));
        check({tag, "_busy"},        64'(busy_o), 64'(0));
        check({tag, "_error"},       64'(error_o), 64'(0));
    endtask

    // One command of v.len beats: issue reads under credit, return data one cycle later.
    task automatic run_vec(input int idx, input vec_t v);
        int issued;
        int pending;
        int cycles;
        bit cmd_sent;
        bit done;
        issued = 0; pending = 0; cycles = 0; cmd_sent = 0; done = 0;
        hs_total = 0;
        cur_mask = v.mask;
        while (!done && cycles < 300) begin
            cmd_valid_i     = !cmd_sent;
            cmd_len_i       = LW'(v.len);
            cmd_mask_i      = v.mask;
            operand_valid_i = 1'b0;
            if (pending > 0) begin
                send_data();
                pending--;
            end
            operand_issued_i = (issued < v.len) && operand_queue_ready_o;
            if (operand_issued_i) begin
                issued++;
                pending++;
            end
            operand_ready_i = v.rnd_ready ? NC'($urandom) : '1;
            if (cmd_valid_i && cmd_ready_o) cmd_sent = 1;
            tick();
            cycles++;
            done = cmd_sent && (issued == v.len) && (pending == 0) && !busy_o;
        end
        idle_inputs();
        check($sformatf("vec%0d_done", idx), 64'(done), 64'(1));
        check($sformatf("vec%0d_hs_count", idx), 64'(hs_total), 64'(v.exp_hs));
        for (int i = 0; i < NC; i++)
            check($sformatf("vec%0d_left_c%0d", idx, i), 64'(exp_q[i].size()), 64'(0));
        check($sformatf("vec%0d_error", idx), 64'(error_o), 64'(0));
        clear_queues();
    endtask

    initial begin
        logic [DW-1:0] d0, d1;
        int            n;
        bit            any_valid;

        vecs[0] = '{4, 3'b111, 1'b0, 12};
        vecs[1] = '{3, 3'b010, 1'b1, 3};
        vecs[2] = '{5, 3'b101, 1'b1, 10};
        vecs[3] = '{1, 3'b001, 1'b0, 1};
        vecs[4] = '{6, 3'b110, 1'b1, 12};
        vecs[5] = '{2, 3'b000, 1'b0, 0};
        vecs[6] = '{0, 3'b111, 1'b0, 0};
        vecs[7] = '{8, 3'b111, 1'b1, 24};

        idle_inputs();
        cur_mask = '0;
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        check_reset_outputs("rst_hold");
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Table-driven commands
        for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

        // Skewed accept: consumer 0 at cycle 0, consumer 2 at cycle 3
        cur_mask = 3'b101;
        cmd_valid_i = 1'b1; cmd_len_i = LW'(2); cmd_mask_i = 3'b101; operand_issued_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0; send_data(); d0 = operand_i;
        tick();
        operand_issued_i = 1'b0; send_data(); d1 = operand_i;
        tick();
        operand_valid_i = 1'b0;
        n = 0;
        while (operand_valid_o !== 3'b101 && n < 20) begin tick(); n++; end
        check("skew_offer_beat0", 64'(operand_valid_o), 64'(3'b101));
        operand_ready_i = 3'b001; #1;
        check("skew_c0_beat0", operand_o, d0);
        tick();
        operand_ready_i = 3'b000; #1;
        check("skew_no_reoffer_1", 64'(operand_valid_o), 64'(3'b100));
        tick();
        #1;
        check("skew_no_reoffer_2", 64'(operand_valid_o), 64'(3'b100));
        tick();
        operand_ready_i = 3'b100; #1;
        check("skew_c2_beat0", operand_o, d0);
        tick();
        operand_ready_i = 3'b000; #1;
        check("skew_beat1_valid", 64'(operand_valid_o), 64'(3'b101));
        check("skew_beat1_data", operand_o, d1);
        operand_ready_i = 3'b101;
        tick();
        operand_ready_i = 3'b000; #1;
        check("skew_done_busy", 64'(busy_o), 64'(0));
        check("skew_done_valid", 64'(operand_valid_o), 64'(0));
        clear_queues();

        // Credit limit with consumers stalled
        cur_mask = 3'b001;
        cmd_valid_i = 1'b1; cmd_len_i = LW'(4); cmd_mask_i = 3'b001; operand_issued_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0; send_data(); tick();
        send_data(); tick();
        send_data(); tick();
        operand_issued_i = 1'b0; send_data(); #1;
        check("credit_after_4th_issue", 64'(operand_queue_ready_o), 64'(0));
        tick();
        operand_valid_i = 1'b0; #1;
        check("credit_full_stored", 64'(operand_queue_ready_o), 64'(0));
        check("credit_offer", 64'(operand_valid_o), 64'(3'b001));
        tick();
        operand_ready_i = 3'b001;
        tick();
        operand_ready_i = 3'b000; #1;
        check("credit_return", 64'(operand_queue_ready_o), 64'(1));
        operand_ready_i = 3'b001;
        n = 0;
        while (busy_o && n < 30) begin tick(); n++; end
        operand_ready_i = 3'b000;
        check("credit_drain", 64'(busy_o), 64'(0));
        check("credit_left_c0", 64'(exp_q[0].size()), 64'(0));
        clear_queues();

        // len=0 command then len=1 mask=0 with one datum
        cur_mask = 3'b000;
        operand_ready_i = '1;
        cmd_valid_i = 1'b1; cmd_len_i = LW'(0); cmd_mask_i = 3'b111;
        tick();
        cmd_len_i = LW'(1); cmd_mask_i = 3'b000; operand_issued_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0; operand_issued_i = 1'b0; send_data();
        any_valid = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (operand_valid_o != '0) any_valid = 1;
            tick();
            operand_valid_i = 1'b0;
        end
        check("corner_no_valid", 64'(any_valid), 64'(0));
        check("corner_busy", 64'(busy_o), 64'(0));
        check("corner_error", 64'(error_o), 64'(0));
        idle_inputs();

`ifdef ARA_OPQ_BYPASS_EN
        // Zero-latency forward with an empty FIFO
        cur_mask = 3'b001;
        cmd_valid_i = 1'b1; cmd_len_i = LW'(1); cmd_mask_i = 3'b001; operand_issued_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0; operand_issued_i = 1'b0;
        tick();
        send_data(); d0 = operand_i; operand_ready_i = 3'b001; #1;
        check("bypass_valid", 64'(operand_valid_o), 64'(3'b001));
        check("bypass_data", operand_o, d0);
        tick();
        idle_inputs(); #1;
        check("bypass_fifo_empty", 64'(busy_o), 64'(0));
        clear_queues();
`endif

        // Uncredited data sets the sticky error and is dropped
        operand_valid_i = 1'b1; operand_i = 64'hDEAD_BEEF_0000_0001;
        tick();
        operand_valid_i = 1'b0; #1;
        check("err_flag", 64'(error_o), 64'(1));
        check("err_not_stored", 64'(busy_o), 64'(0));
        check("err_operand_o", operand_o, 64'(0));
        tick();

        // Reset mid-stream with two queued commands and a partial handshake
        cur_mask = 3'b111;
        cmd_valid_i = 1'b1; cmd_len_i = LW'(3); cmd_mask_i = 3'b111; operand_issued_i = 1'b1;
        tick();
        send_data();
        tick();
        cmd_valid_i = 1'b0; operand_issued_i = 1'b0; send_data();
        tick();
        operand_valid_i = 1'b0; operand_ready_i = 3'b001;
        tick();
        operand_ready_i = 3'b000; #1;
        check("pre_reset_busy", 64'(busy_o), 64'(1));
        check("pre_reset_taken", 64'(operand_valid_o), 64'(3'b110));
        rst_ni = 1'b0; #1;
        check_reset_outputs("rst_mid");
        clear_queues();
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        #1;
        check_reset_outputs("rst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/operand_fanout_queue.md
OPERAND_FANOUT_QUEUE -- requirements
Module: operand_fanout_queue

Interface
REQ-001 SHALL have parameter DataWidth, default 64: operand word width in bits.
REQ-002 SHALL have parameter DataBufDepth, default 4 (range 1..16): data FIFO entries.
REQ-003 SHALL have parameter CmdBufDepth, default 4 (range 1..8): command FIFO entries.
REQ-004 SHALL have parameter NrConsumers, default 3 (range 1..8): number of consumer ports.
REQ-005 SHALL have parameter LenWidth, default 16: width of the beat-count field.
REQ-006 Ports SHALL be:
  clk_i  in  1  clock
  rst_ni  in  1  reset; one clock, asynchronous active-low reset
  cmd_len_i  in  LenWidth  number of beats in the command
  cmd_mask_i  in  NrConsumers  consumers receiving each beat
  cmd_valid_i  in  1  command valid
  cmd_ready_o  out  1  command FIFO not full
  operand_issued_i  in  1  requester issued one VRF read
  operand_queue_ready_o  out  1  requester may issue
  operand_i  in  DataWidth  VRF read data
  operand_valid_i  in  1  VRF data arrives
  operand_o  out  DataWidth  head data, shared by all consumers
  operand_valid_o  out  NrConsumers  per-consumer valid
  operand_ready_i  in  NrConsumers  per-consumer ready
  busy_o  out  1  command or data pending
  error_o  out  1  sticky: data arrived with no credit outstanding

Function
REQ-007 A command SHALL be accepted on cmd_valid_i && cmd_ready_o; cmd_ready_o = command FIFO not full.
REQ-008 Credit: inflight increments on operand_issued_i and decrements on operand_valid_i; operand_queue_ready_o = (stored + inflight) < DataBufDepth; simultaneous issue and arrival SHALL leave inflight unchanged.
REQ-009 operand_valid_i with inflight == 0 and no same-cycle issue SHALL drop the data and set error_o.
REQ-010 FSM states: IDLE (command FIFO empty) and STREAM (head command active); IDLE->STREAM when the command FIFO is non-empty; STREAM->IDLE on the last-beat retire when no further command is queued, otherwise it stays in STREAM with the next command.
REQ-011 In STREAM, operand_valid_o[i] = data FIFO non-empty && cmd_mask[i] && !taken[i].
REQ-012 taken[i] SHALL set on operand_valid_o[i] && operand_ready_i[i] when the beat does not retire in that cycle.
REQ-013 A beat SHALL retire in the cycle in which every masked consumer is taken or handshaking; retirement pops the data FIFO, clears all taken flags and increments the beat counter.
REQ-014 A consumer SHALL receive each beat exactly once, regardless of the order in which consumers accept.
REQ-015 When the retiring beat is beat cmd_len-1, the command SHALL pop and the beat counter SHALL reset to 0 in the same cycle.
REQ-016 cmd_mask == 0: beats SHALL be discarded at one per cycle while data is present, with all operand_valid_o low.
REQ-017 cmd_len == 0: the command SHALL pop one cycle after reaching the head and SHALL consume no data.
REQ-018 Data arriving while the data FIFO is full SHALL not occur given REQ-008; the FIFO SHALL not overwrite.
REQ-019 The data and command FIFOs SHALL wrap their pointers modulo their depth.
REQ-020 busy_o = command FIFO non-empty || stored != 0 || inflight != 0.
REQ-021 Latency (macro absent): data written at edge N SHALL be visible on operand_o after edge N.

Reset
REQ-022 While rst_ni is low: FIFOs empty, inflight = 0, beat counter = 0, taken = 0, FSM = IDLE, error_o = 0.
REQ-023 Reset values of outputs: cmd_ready_o = 1, operand_queue_ready_o = 1, operand_valid_o = 0, operand_o = 0, busy_o = 0.
REQ-024 Reset asserted mid-stream SHALL discard all pending commands, data and credits without emitting a partial handshake.

Configuration
REQ-025 Macro ARA_OPQ_BYPASS_EN defined: when the data FIFO is empty and the head command is in STREAM, operand_i/operand_valid_i SHALL drive operand_o and operand_valid_o combinationally, giving zero-cycle latency. The word SHALL be written to the FIFO only if it does not retire in that cycle; taken flags SHALL record any partial acceptance.
REQ-026 Macro ARA_OPQ_BYPASS_EN undefined: no combinational path from operand_i to operand_o; latency per REQ-021.

Verification
REQ-027 Broadcast: NrConsumers=3, cmd len=4 mask=3'b111, all ready=1, data A..D -> each consumer sees A,B,C,D; command pops after D; busy_o falls.
REQ-028 Skewed accept: len=2 mask=3'b101; ready[0]=1 at cycle 0, ready[2]=1 at cycle 3 -> beat 0 retires at cycle 3; consumer 0 is not re-offered beat 0; beat 1 follows.
REQ-029 Credit: DataBufDepth=4, issue 4 reads with consumers stalled -> operand_queue_ready_o=0 after the 4th issue; it returns to 1 on the first retire.
REQ-030 Corner commands: len=0 followed by len=1 mask=0 with one datum -> first command pops with no data; datum discarded; no operand_valid_o asserted.
REQ-031 Error and reset: operand_valid_i with no credit -> error_o=1 and stored unchanged; rst_ni low mid-STREAM with 2 queued commands -> all outputs return to their reset values.
REQ-032 Bypass (macro defined): empty FIFO, len=1 mask=1, ready=1, operand_valid_i=1 -> operand_valid_o[0]=1 in the same cycle and the FIFO stays empty.
